generic_reader_writer_regfile: RTL and testbench



---
 rtl/generic_reader_writer_regfile_pkg.sv | 20 ++
 rtl/generic_reader_writer_regfile.sv | 265 ++++++++++++++++++++++++++
 tb/tb_generic_reader_writer_regfile.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/generic_reader_writer_regfile_pkg.sv
// rtl/generic_reader_writer_regfile_pkg.sv - register-bus request/response types for the reader/writer regfile
package generic_reader_writer_regfile_pkg;

    // Register-bus request: 6-bit byte address, 32-bit data, byte strobes.
    typedef struct packed {
        logic [5:0]  addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    // Register-bus response: ready pulses for one cycle per accepted access.
    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/generic_reader_writer_regfile.sv
// rtl/generic_reader_writer_regfile.sv - job descriptor registers and start/done handshake for the generic reader/writer
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   cfg_req_i, cfg_rsp_o  register bus (request seen in N, response with ready in N+1)
//   start_o               one-cycle job start pulse
//   mode_o, addr_o,
//   len_o, wdata_o        job descriptor, held stable while the job is running
//   done_i, err_i,
//   rdata_i               engine completion, error and read data (sampled with done_i)
//   irq_o                 level interrupt: IRQ_EN & DONE, registered
//
// Build option: GENERIC_READER_WRITER_IRQ_EN enables the IRQ_EN bit and irq_o;
// without it IRQ_EN reads 0, writes to it are dropped and irq_o is tied 0.
module generic_reader_writer_regfile
    import generic_reader_writer_regfile_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter logic [31:0] ID_VALUE   = 32'h4752_5701
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  reg_req_t              cfg_req_i,
    output reg_rsp_t              cfg_rsp_o,
    output logic                  start_o,
    output logic                  mode_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [LEN_WIDTH-1:0]  len_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic                  done_i,
    input  logic                  err_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    output logic                  irq_o
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    // Word index = byte offset / 4.
    localparam logic [3:0] IDX_CTRL     = 4'd0;
    localparam logic [3:0] IDX_STATUS   = 4'd1;
    localparam logic [3:0] IDX_ADDR_LO  = 4'd2;
    localparam logic [3:0] IDX_ADDR_HI  = 4'd3;
    localparam logic [3:0] IDX_LEN      = 4'd4;
    localparam logic [3:0] IDX_WDATA_LO = 4'd5;
    localparam logic [3:0] IDX_WDATA_HI = 4'd6;
    localparam logic [3:0] IDX_RDATA_LO = 4'd7;
    localparam logic [3:0] IDX_RDATA_HI = 4'd8;
    localparam logic [3:0] IDX_ID       = 4'd9;

    state_t                state_q, state_d;
    logic                  irq_en_q, irq_en_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  start_q, start_d;
    reg_rsp_t              rsp_q, rsp_d;

    // A write is validated in the request cycle and committed one cycle later
    // from this captured copy.
    logic                  wr_q, wr_d;
    logic [3:0]            wr_idx_q, wr_idx_d;
    logic [3:0]            wr_strb_q, wr_strb_d;
    logic [31:0]           wr_data_q, wr_data_d;

    logic [63:0]           addr_ext;
    logic [31:0]           len_ext;
    logic                  busy;
    logic                  accept;
    logic                  aligned;
    logic                  mapped;
    logic                  ro_reg;
    logic                  locked_reg;
    logic                  mode_clash;
    logic                  req_err;
    logic [3:0]            idx;
    logic [31:0]           rd_val;

    function automatic logic [31:0] merge32(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Zero-extended views so bits above the configured widths read as 0.
    assign addr_ext = 64'(addr_q);
    assign len_ext  = 32'(len_q);

    assign busy    = (state_q == S_BUSY);
    assign idx     = cfg_req_i.addr[5:2];
    assign aligned = (cfg_req_i.addr[1:0] == 2'b00);
    // The ready cycle itself never accepts, giving at most one access per 2 cycles.
    assign accept  = cfg_req_i.valid & ~rsp_q.ready;

    always_comb begin
        rd_val = '0;
        mapped = 1'b1;
        case (idx)
            IDX_CTRL:     rd_val = {29'd0, mode_q, irq_en_q, 1'b0};
            IDX_STATUS:   rd_val = {29'd0, err_q, done_q, busy};
            IDX_ADDR_LO:  rd_val = addr_ext[31:0];
            IDX_ADDR_HI:  rd_val = addr_ext[63:32];
            IDX_LEN:      rd_val = len_ext;
            IDX_WDATA_LO: rd_val = wdata_q[31:0];
            IDX_WDATA_HI: rd_val = wdata_q[63:32];
            IDX_RDATA_LO: rd_val = rdata_q[31:0];
            IDX_RDATA_HI: rd_val = rdata_q[63:32];
            IDX_ID:       rd_val = ID_VALUE;
            default:      mapped = 1'b0;
        endcase
    end

    assign ro_reg     = idx inside {IDX_RDATA_LO, IDX_RDATA_HI, IDX_ID};
    assign locked_reg = busy & (idx inside {IDX_ADDR_LO, IDX_ADDR_HI, IDX_LEN,
                                            IDX_WDATA_LO, IDX_WDATA_HI});
    // A CTRL write during a job is fine unless it tries to flip MODE.
    assign mode_clash = busy & (idx == IDX_CTRL) & cfg_req_i.wstrb[0]
                      & (cfg_req_i.wdata[2] != mode_q);
    assign req_err    = ~aligned | ~mapped
                      | (cfg_req_i.write & (ro_reg | locked_reg | mode_clash));

    always_comb begin
        state_d   = state_q;
        irq_en_d  = irq_en_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        len_d     = len_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        done_d    = done_q;
        err_d     = err_q;
        start_d   = 1'b0;

        rsp_d       = '0;
        rsp_d.ready = accept;
        rsp_d.error = accept & req_err;
        rsp_d.rdata = (accept & ~cfg_req_i.write & ~req_err) ? rd_val : 32'd0;

        wr_d      = accept & cfg_req_i.write & ~req_err;
        wr_idx_d  = idx;
        wr_strb_d = cfg_req_i.wstrb;
        wr_data_d = cfg_req_i.wdata;

        if (wr_q) begin
            case (wr_idx_q)
                IDX_CTRL: begin
                    if (wr_strb_q[0]) begin
`ifdef GENERIC_READER_WRITER_IRQ_EN
                        irq_en_d = wr_data_q[1];
`endif
                        // While busy, START is ignored and MODE is known unchanged.
                        if (state_q == S_IDLE) begin
                            mode_d = wr_data_q[2];
                            if (wr_data_q[0]) begin
                                if (len_q != '0) begin
                                    state_d = S_BUSY;
                                    start_d = 1'b1;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                IDX_STATUS: begin
                    if (wr_strb_q[0]) begin
                        if (wr_data_q[1]) done_d = 1'b0;
                        if (wr_data_q[2]) err_d  = 1'b0;
                    end
                end
                IDX_ADDR_LO:  addr_d  = ADDR_WIDTH'({addr_ext[63:32],
                                                     merge32(addr_ext[31:0], wr_data_q, wr_strb_q)});
                IDX_ADDR_HI:  addr_d  = ADDR_WIDTH'({merge32(addr_ext[63:32], wr_data_q, wr_strb_q),
                                                     addr_ext[31:0]});
                IDX_LEN:      len_d   = LEN_WIDTH'(merge32(len_ext, wr_data_q, wr_strb_q));
                IDX_WDATA_LO: wdata_d = {wdata_q[63:32], merge32(wdata_q[31:0], wr_data_q, wr_strb_q)};
                IDX_WDATA_HI: wdata_d = {merge32(wdata_q[63:32], wr_data_q, wr_strb_q), wdata_q[31:0]};
                default: ;
            endcase
        end

        // Completion is applied after the W1C so a coincident set wins.
        if (busy & done_i) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (err_i) err_d = 1'b1;
            if (!mode_q) rdata_d = rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            irq_en_q  <= 1'b0;
            mode_q    <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            rsp_q     <= '0;
            wr_q      <= 1'b0;
            wr_idx_q  <= '0;
            wr_strb_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            irq_en_q  <= irq_en_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            start_q   <= start_d;
            rsp_q     <= rsp_d;
            wr_q      <= wr_d;
            wr_idx_q  <= wr_idx_d;
            wr_strb_q <= wr_strb_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef GENERIC_READER_WRITER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_en_q & done_q;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

    assign cfg_rsp_o = rsp_q;
    assign start_o   = start_q;
    assign mode_o    = mode_q;
    assign addr_o    = addr_q;
    assign len_o     = len_q;
    assign wdata_o   = wdata_q;

endmodule

// File: tb/tb_generic_reader_writer_regfile.sv
// tb/tb_generic_reader_writer_regfile.sv - scoreboard bench for generic_reader_writer_regfile
module tb_generic_reader_writer_regfile;
    import generic_reader_writer_regfile_pkg::*;

    localparam logic [31:0] ID_CONST = 32'h4752_5701;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    reg_req_t    req;
    reg_rsp_t    rsp;
    logic        start;
    logic        mode;
    logic [63:0] addr;
    logic [15:0] len;
    logic [63:0] wdata;
    logic        done = 1'b0;
    logic        eng_err = 1'b0;
    logic [63:0] rdata_in = '0;
    logic        irq;

    always #5 clk = ~clk;

    generic_reader_writer_regfile dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .cfg_req_i (req),
        .cfg_rsp_o (rsp),
        .start_o   (start),
        .mode_o    (mode),
        .addr_o    (addr),
        .len_o     (len),
        .wdata_o   (wdata),
        .done_i    (done),
        .err_i     (eng_err),
        .rdata_i   (rdata_in),
        .irq_o     (irq)
    );

    int checks = 0;
    int errors = 0;
    int irq_high_cycles = 0;
    int acc_n = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
        string       name;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [15:0] len;
        logic        mode;
        logic [63:0] wdata;
    } job_t;

    exp_t exp_q[$];
    job_t job_q[$];

    // Reference model: register contents as plain variables.
    bit          m_busy, m_done, m_err, m_mode, m_irq_en;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [31:0] m_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0; m_done = 0; m_err = 0; m_mode = 0; m_irq_en = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_len = '0;
    endfunction

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        case (idx)
            0: return {29'd0, m_mode, m_irq_en, 1'b0};
            1: return {29'd0, m_err, m_done, m_busy};
            2: return m_addr[31:0];
            3: return m_addr[63:32];
            4: return m_len;
            5: return m_wdata[31:0];
            6: return m_wdata[63:32];
            7: return m_rdata[31:0];
            8: return m_rdata[63:32];
            default: return ID_CONST;
        endcase
    endfunction

    function automatic void model_access(input logic [5:0] a, input bit w, input logic [31:0] d,
                                         input logic [3:0] s, output logic [31:0] er, output logic ee);
        int idx;
        idx = int'(a[5:2]);
        er = '0;
        ee = 1'b0;
        if (a[1:0] != 2'b00 || idx > 9) begin
            ee = 1'b1;
            return;
        end
        if (!w) begin
            er = m_read(idx);
            return;
        end
        case (idx)
            0: begin
                if (m_busy && s[0] && d[2] != m_mode) begin
                    ee = 1'b1;
                end else if (s[0]) begin
`ifdef GENERIC_READER_WRITER_IRQ_EN
                    m_irq_en = d[1];
`endif
                    if (!m_busy) begin
                        m_mode = d[2];
                        if (d[0]) begin
                            if (m_len != 0) begin
                                m_busy = 1;
                                job_q.push_back('{m_addr, m_len[15:0], m_mode, m_wdata});
                            end else begin
                                m_err = 1;
                            end
                        end
                    end
                end
            end
            1: if (s[0]) begin
                if (d[1]) m_done = 0;
                if (d[2]) m_err = 0;
            end
            2, 3, 4, 5, 6: begin
                if (m_busy) ee = 1'b1;
                else case (idx)
                    2: m_addr[31:0]  = bytes_merge(m_addr[31:0], d, s);
                    3: m_addr[63:32] = bytes_merge(m_addr[63:32], d, s);
                    4: m_len         = bytes_merge(m_len, d, s) & 32'h0000_FFFF;
                    5: m_wdata[31:0] = bytes_merge(m_wdata[31:0], d, s);
                    default: m_wdata[63:32] = bytes_merge(m_wdata[63:32], d, s);
                endcase
            end
            default: ee = 1'b1;
        endcase
    endfunction

    function automatic void model_done(input bit e, input logic [63:0] d);
        if (m_busy) begin
            m_busy = 0;
            m_done = 1;
            if (e) m_err = 1;
            if (!m_mode) m_rdata = d;
        end
    endfunction

    // Issue one register access; optionally pulse done_i in the commit cycle.
    task automatic access(input logic [5:0] a, input bit w, input logic [31:0] d,
                          input logic [3:0] s, input bit with_done, input logic [63:0] drd);
        exp_t e;
        bit   was_busy;
        bit   got;
        was_busy = m_busy;
        model_access(a, w, d, s, e.rdata, e.error);
        if (with_done && was_busy) model_done(1'b0, drd);
        e.name = $sformatf("acc%0d_%s_%02h", acc_n, w ? "wr" : "rd", a);
        acc_n++;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req.addr = a; req.write = w; req.wdata = d; req.wstrb = s; req.valid = 1'b1;
        @(posedge clk); #1;
        if (with_done) begin
            done = 1'b1; eng_err = 1'b0; rdata_in = drd;
        end
        got = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp.ready) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: ready=0 required=1", e.name);
            void'(exp_q.pop_back());
        end
        @(posedge clk); #1;
        req.valid = 1'b0;
        done = 1'b0;
    endtask

    task automatic rd(input logic [5:0] a);
        access(a, 1'b0, 32'd0, 4'h0, 1'b0, 64'd0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        access(a, 1'b1, d, 4'hF, 1'b0, 64'd0);
    endtask

    task automatic engine_done(input bit e, input logic [63:0] d);
        @(posedge clk); #1;
        done = 1'b1; eng_err = e; rdata_in = d;
        @(posedge clk); #1;
        done = 1'b0; eng_err = 1'b0;
        model_done(e, d);
    endtask

    // Monitor: pops expected responses and jobs whenever the DUT presents them.
    always @(negedge clk) begin
        exp_t e;
        job_t j;
        if (rst_n) begin
            if (rsp.ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_ready: ready=1 with no access outstanding");
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_error"}, 64'(rsp.error), 64'(e.error));
                    check({e.name, "_rdata"}, 64'(rsp.rdata), 64'(e.rdata));
                end
            end
            if (start) begin
                if (job_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_start: start_o=1 with no job expected");
                end else begin
                    j = job_q.pop_front();
                    check("job_addr", addr, j.addr);
                    check("job_len", 64'(len), 64'(j.len));
                    check("job_mode", 64'(mode), 64'(j.mode));
                    check("job_wdata", wdata, j.wdata);
                end
            end
        end
        if (irq !== 1'b0) irq_high_cycles++;
    end

    initial begin
        req = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp", 64'(rsp), 64'd0);
        check("reset_start", 64'(start), 64'd0);
        check("reset_irq", 64'(irq), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) rd(6'(i * 4));

        // Read job with busy-time access rules.
        wr(6'h08, 32'h0000_1000);
        wr(6'h10, 32'd4);
        wr(6'h00, 32'h1);
        rd(6'h04);
        wr(6'h10, 32'd8);
        rd(6'h10);
        wr(6'h00, 32'h1);
        wr(6'h00, 32'h4);
        engine_done(1'b0, 64'hDEAD_BEEF_0123_4567);
        rd(6'h04);
        rd(6'h1C);
        rd(6'h20);

        // Zero-length start, W1C of ERR.
        wr(6'h04, 32'h2);
        wr(6'h10, 32'd0);
        wr(6'h00, 32'h1);
        rd(6'h04);
        wr(6'h04, 32'h4);
        rd(6'h04);

        // Unmapped, misaligned, RO writes, partial strobes, bits above LEN_WIDTH.
        rd(6'h28);
        rd(6'h02);
        wr(6'h24, 32'h1);
        wr(6'h1C, 32'h1);
        access(6'h0C, 1'b1, 32'hAABB_CCDD, 4'b0101, 1'b0, 64'd0);
        rd(6'h0C);
        wr(6'h10, 32'hFFFF_0003);
        rd(6'h10);
        wr(6'h0C, 32'h0);

        // DONE W1C in the same cycle as done_i.
        wr(6'h00, 32'h1);
        access(6'h04, 1'b1, 32'h2, 4'hF, 1'b1, 64'h1111_2222_3333_4444);
        rd(6'h04);
        rd(6'h1C);

        // Write job: RDATA not captured.
        wr(6'h14, 32'h5555_6666);
        wr(6'h18, 32'h7777_8888);
        wr(6'h00, 32'h5);
        wr(6'h00, 32'h1);
        engine_done(1'b1, 64'h9999_9999_9999_9999);
        rd(6'h04);
        rd(6'h1C);
        rd(6'h00);

        // Interrupt.
        wr(6'h04, 32'h6);
        wr(6'h00, 32'h2);
        rd(6'h00);
`ifdef GENERIC_READER_WRITER_IRQ_EN
        wr(6'h00, 32'h3);
        repeat (2) @(posedge clk);
        #1;
        done = 1'b1;
        @(negedge clk);
        check("irq_cycle_m", 64'(irq), 64'd0);
        @(posedge clk); #1;
        done = 1'b0;
        model_done(1'b0, rdata_in);
        @(negedge clk);
        check("irq_cycle_m1", 64'(irq), 64'd0);
        @(negedge clk);
        check("irq_cycle_m2", 64'(irq), 64'd1);
        wr(6'h04, 32'h2);
        @(negedge clk);
        check("irq_after_w1c_n2", 64'(irq), 64'd1);
        @(negedge clk);
        check("irq_after_w1c_n3", 64'(irq), 64'd0);
`endif

        // Asynchronous reset in the middle of a job.
        wr(6'h10, 32'd3);
        wr(6'h00, 32'h1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_addr", addr, 64'd0);
        check("async_rst_len", 64'(len), 64'd0);
        check("async_rst_rsp", 64'(rsp), 64'd0);
        check("async_rst_irq", 64'(irq), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        engine_done(1'b1, 64'hFFFF_0000_FFFF_0000);
        rd(6'h04);
        rd(6'h1C);
        rd(6'h10);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            case (r)
                0, 1: rd(6'($urandom_range(0, 63)));
                2, 3: rd(6'($urandom_range(0, 9) * 4));
                4: access(6'($urandom_range(2, 6) * 4), 1'b1,
                          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : 32'($urandom),
                          4'($urandom_range(0, 15)), 1'b0, 64'd0);
                5: access(6'h00, 1'b1, 32'($urandom_range(0, 7)),
                          ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF, 1'b0, 64'd0);
                6: access(6'h04, 1'b1, 32'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0, 64'd0);
                7: access(6'($urandom_range(7, 15) * 4), 1'b1, 32'($urandom), 4'hF, 1'b0, 64'd0);
                default: begin
                    if (m_busy) engine_done(1'($urandom_range(0, 1)), {32'($urandom), 32'($urandom)});
                    else rd(6'h04);
                end
            endcase
        end

        repeat (4) @(posedge clk);
        check("leftover_responses", 64'(exp_q.size()), 64'd0);
        check("leftover_jobs", 64'(job_q.size()), 64'd0);
`ifndef GENERIC_READER_WRITER_IRQ_EN
        check("irq_tied_low_cycles", 64'(irq_high_cycles), 64'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
